seq_divider: RTL and testbench

- Parameterised multi-cycle restoring divider with runtime signed/unsigned mode.
- Uses valid/ready handshakes on both input and output, and flags divide-by-zero and signed overflow.
- Replaces the fixed-mode unsigned divider in arithmetic datapaths that need back-pressure and signed support.

---
 rtl/seq_divider_if.sv | 27 ++
 rtl/seq_divider.sv | 114 +++++++++++
 tb/tb_seq_divider.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// The master drives operands and out_ready; the slave (divider) drives everything else.
interface seq_divider_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic         is_signed;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    modport master (
        output in_valid, is_signed, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, is_signed, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, runtime signed/unsigned, fixed N+2 cycle latency.
// Divide-by-zero and most-negative / -1 are flagged and given defined results.
module seq_divider #(
    parameter int N = 16
) (
    input  logic        CLK,
    input  logic        RST,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t         r_state, w_next;
    logic [N-1:0]   r_dvd, r_dvs, r_b, r_rem, r_quo;
    logic           r_sgn, r_sign_q, r_sign_r, r_zero, r_ovf;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_q_out, r_r_out;
    logic           r_dz_out, r_ov_out;

    logic [N:0]     w_rem_sh, w_trial;
    logic           w_take;
    logic [N-1:0]   w_fix_q, w_fix_r;

    // A set top bit in the shifted remainder already guarantees it exceeds the divisor.
    assign w_rem_sh = {r_rem, r_quo[N-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_b};
    assign w_take   = w_rem_sh[N] | ~w_trial[N];
    assign w_fix_q  = r_sign_q ? -r_quo : r_quo;
    assign w_fix_r  = r_sign_r ? -r_rem : r_rem;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_next = PREP;
            PREP:    w_next = ITER;
            ITER:    if (r_cnt == CW'(N - 1)) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_sgn    <= 1'b0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_q_out  <= '0;
            r_r_out  <= '0;
            r_dz_out <= 1'b0;
            r_ov_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_dvd <= bus.dividend;
                    r_dvs <= bus.divisor;
                    r_sgn <= bus.is_signed;
                end
                PREP: begin
                    r_quo    <= (r_sgn && r_dvd[N-1]) ? -r_dvd : r_dvd;
                    r_b      <= (r_sgn && r_dvs[N-1]) ? -r_dvs : r_dvs;
                    r_rem    <= '0;
                    r_cnt    <= '0;
                    r_sign_q <= r_sgn & (r_dvd[N-1] ^ r_dvs[N-1]);
                    r_sign_r <= r_sgn & r_dvd[N-1];
                    r_zero   <= (r_dvs == '0);
                    r_ovf    <= r_sgn && (r_dvd == {1'b1, {(N-1){1'b0}}}) && (&r_dvs);
                end
                ITER: begin
                    r_rem <= w_take ? w_trial[N-1:0] : w_rem_sh[N-1:0];
                    r_quo <= {r_quo[N-2:0], w_take};
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    r_q_out  <= w_fix_q;
                    r_r_out  <= w_fix_r;
                    r_dz_out <= 1'b0;
                    r_ov_out <= 1'b0;
                    if (r_zero) begin
                        r_q_out  <= '1;
                        r_r_out  <= r_dvd;
                        r_dz_out <= 1'b1;
                    end else if (r_ovf) begin
                        r_q_out  <= r_dvd;
                        r_r_out  <= '0;
                        r_ov_out <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == IDLE);
    assign bus.out_valid   = (r_state == DONE);
    assign bus.quotient    = r_q_out;
    assign bus.remainder   = r_r_out;
    assign bus.div_by_zero = r_dz_out;
    assign bus.overflow    = r_ov_out;
endmodule

// File: tb/tb_seq_divider.sv
// Directed + random bench for seq_divider (N=8) with a result scoreboard.
module tb_seq_divider;
    localparam int N = 8;

    logic CLK = 1'b0;
    logic RST;

    seq_divider_if #(.N(N)) bus ();
    seq_divider #(.N(N)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ov;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   acc_cyc  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        exp_t e;
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else if (s && a == {1'b1, {(N-1){1'b0}}} && b == '1) begin
            e.q  = a;
            e.r  = '0;
            e.ov = 1'b1;
        end else if (s) begin
            e.q = N'($signed(a) / $signed(b));
            e.r = N'($signed(a) % $signed(b));
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Called at a negedge; returns 1ns after the accepting edge.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        int t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (!bus.in_ready) begin
            chk("send_timeout_in_ready", bus.in_ready, 1);
        end else begin
            bus.in_valid  = 1'b1;
            bus.dividend  = a;
            bus.divisor   = b;
            bus.is_signed = s;
            @(posedge CLK);
            #1;
            acc_cyc = cyc;
            sb.push_back(model(a, b, s));
            bus.in_valid = 1'b0;
            bus.dividend = '1;
            bus.divisor  = '1;
        end
    endtask

    // Returns at the negedge where out_valid is first seen.
    task automatic recv(input string tag);
        exp_t e;
        int   t = 0;
        @(negedge CLK);
        while (!bus.out_valid && t < 40) begin
            @(negedge CLK);
            t++;
        end
        if (!bus.out_valid) begin
            chk({tag, "_timeout_out_valid"}, bus.out_valid, 1);
        end else if (sb.size() == 0) begin
            chk({tag, "_unexpected_result"}, sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_latency"}, cyc - acc_cyc, N + 2);
            chk({tag, "_quotient"}, bus.quotient, e.q);
            chk({tag, "_remainder"}, bus.remainder, e.r);
            chk({tag, "_div_by_zero"}, bus.div_by_zero, e.dz);
            chk({tag, "_overflow"}, bus.overflow, e.ov);
        end
    endtask

    task automatic op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        send(a, b, s);
        recv(tag);
        @(negedge CLK);
        chk({tag, "_pulse_one_cycle"}, bus.out_valid, 0);
    endtask

    initial begin
        logic [N-1:0] hold_q, hold_r;
        int           seen;

        RST           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_dz", bus.div_by_zero, 0);
        chk("rst_ov", bus.overflow, 0);
        RST = 1'b0;
        @(negedge CLK);

        op("u200_7", 8'd200, 8'd7, 1'b0);
        op("s_m100_7", 8'h9C, 8'h07, 1'b1);
        op("s_100_m7", 8'd100, 8'hF9, 1'b1);
        op("u45_0", 8'd45, 8'd0, 1'b0);
        op("sFB_0", 8'hFB, 8'd0, 1'b1);
        op("s80_FF", 8'h80, 8'hFF, 1'b1);
        op("u80_FF", 8'h80, 8'hFF, 1'b0);
        op("uFF_1", 8'hFF, 8'h01, 1'b0);
        op("s80_1", 8'h80, 8'h01, 1'b1);
        for (int i = 0; i < 8; i++) begin
            op($sformatf("rand%0d", i), N'($urandom), N'($urandom_range(1, 255)), 1'($urandom));
        end

        // Back-pressure: hold results while a stray in_valid arrives.
        bus.out_ready = 1'b0;
        send(8'd200, 8'd7, 1'b0);
        recv("bp");
        hold_q = bus.quotient;
        hold_r = bus.remainder;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.in_valid = 1'b1;
                bus.dividend = 8'd9;
                bus.divisor  = 8'd3;
            end
            @(negedge CLK);
            bus.in_valid = 1'b0;
            chk($sformatf("bp_hold_valid%0d", i), bus.out_valid, 1);
            chk($sformatf("bp_in_ready%0d", i), bus.in_ready, 0);
            chk($sformatf("bp_hold_q%0d", i), bus.quotient, hold_q);
            chk($sformatf("bp_hold_r%0d", i), bus.remainder, hold_r);
        end
        bus.out_ready = 1'b1;
        @(negedge CLK);
        chk("bp_release_valid", bus.out_valid, 0);
        chk("bp_release_in_ready", bus.in_ready, 1);
        send(8'd77, 8'd10, 1'b0);
        chk("bp_next_accept_cycle", cyc - acc_cyc, 0);
        recv("bp_next");
        @(negedge CLK);
        chk("bp_queue_empty", sb.size(), 0);

        // Reset in the middle of ITER.
        send(8'd200, 8'd7, 1'b0);
        repeat (3) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_quotient", bus.quotient, 0);
        chk("midrst_remainder", bus.remainder, 0);
        chk("midrst_dz", bus.div_by_zero, 0);
        chk("midrst_ov", bus.overflow, 0);
        sb.delete();
        @(negedge CLK);
        RST  = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (bus.out_valid) seen++;
        end
        chk("midrst_no_pulse", seen, 0);
        op("post_rst_u200_7", 8'd200, 8'd7, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
